serial_adder: RTL and testbench

Parametrised multi-bit adder that computes A+B+cin over several clock cycles, DIGIT bits per cycle. It uses a chain of DIGIT full-adder cells plus a registered carry. It replaces the single-bit combinational full adder wherever wide additions are needed at low area. Operands enter and results leave through valid/ready handshakes.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/fa_cell.sv | 13 +
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width; a single-step adder still needs one bit.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit combinational full adder, one link of the per-cycle ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a+b+cin, DIGIT bits per cycle, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: DIGIT must divide WIDTH exactly");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    step;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] s;
  logic             last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  assign c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    fa_cell u_fa (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .cin  (c[i]),
      .sum  (s[i]),
      .carry(c[i+1])
    );
  end

  assign last = (step == CW'(STEPS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      step    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            step    <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          // Sum digits enter at the MSB end so the first digit lands at bit 0.
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          sum_q   <= WIDTH'({s, sum_q} >> DIGIT);
          carry_q <= c[DIGIT];
          step    <= step + CW'(1);
          if (last) begin
            cout_q <= c[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q  <= c[DIGIT-1] ^ c[DIGIT];
`endif
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three configurations (8/1, 8/2, 4/4) on one clock.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin_in;
  logic [2:0] in_valid;
  logic       out_ready;
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [2:0] busy;
  logic [2:0] cout;
  logic [7:0] sum0;
  logic [7:0] sum1;
  logic [3:0] sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic [2:0] ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_in), .b(b_in), .cin(cin_in), .out_valid(out_valid[0]),
    .out_ready(out_ready), .sum(sum0), .cout(cout[0]),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf[0]),
`endif
    .busy(busy[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_in), .b(b_in), .cin(cin_in), .out_valid(out_valid[1]),
    .out_ready(out_ready), .sum(sum1), .cout(cout[1]),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf[1]),
`endif
    .busy(busy[1])
  );

  serial_adder #(.WIDTH(4), .DIGIT(4)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin_in), .out_valid(out_valid[2]),
    .out_ready(out_ready), .sum(sum2), .cout(cout[2]),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf[2]),
`endif
    .busy(busy[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sum_of(input int sel);
    case (sel)
      0:       return sum0;
      1:       return sum1;
      default: return {4'h0, sum2};
    endcase
  endfunction

  function automatic int width_of(input int sel);
    return (sel == 2) ? 4 : 8;
  endfunction

  function automatic int steps_of(input int sel);
    case (sel)
      0:       return 8;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  // One complete transaction: accept, measure latency, check result, optional
  // backpressure hold, release, and check the return to IDLE.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input int hold, input bit poke, input string tag);
    int         w;
    int         n;
    logic [7:0] mask;
    logic [7:0] aa;
    logic [7:0] bb;
    logic [8:0] full;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
    w        = width_of(sel);
    mask     = (w == 8) ? 8'hFF : 8'h0F;
    aa       = a & mask;
    bb       = b & mask;
    full     = {1'b0, aa} + {1'b0, bb} + {8'h00, c};
    exp_sum  = full[7:0] & mask;
    exp_cout = full[w];
    exp_ovf  = (aa[w-1] == bb[w-1]) && (exp_sum[w-1] != aa[w-1]);

    check({tag, "_ready"}, {31'd0, in_ready[sel]}, 32'd1);
    a_in          = a;
    b_in          = b;
    cin_in        = c;
    out_ready     = (hold == 0);
    in_valid[sel] = 1'b1;
    @(posedge clk); #1;
    in_valid[sel] = poke;
    n = 0;
    while (!out_valid[sel] && n < 64) begin
      if (poke) begin
        a_in   = ~a_in;
        b_in   = b_in + 8'h37;
        cin_in = ~cin_in;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid[sel] = 1'b0;
    check({tag, "_lat"}, n, steps_of(sel));
    check({tag, "_sum"}, {24'd0, sum_of(sel)}, {24'd0, exp_sum});
    check({tag, "_cout"}, {31'd0, cout[sel]}, {31'd0, exp_cout});
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf[sel]}, {31'd0, exp_ovf});
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"},
            {20'd0, out_valid[sel], in_ready[sel], busy[sel], sum_of(sel), cout[sel]},
            {20'd0, 1'b1, 1'b0, 1'b1, exp_sum, exp_cout});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle"}, {29'd0, in_ready[sel], out_valid[sel], busy[sel]}, 32'b100);
    check({tag, "_keep"}, {23'd0, sum_of(sel), cout[sel]}, {23'd0, exp_sum, exp_cout});
  endtask

  initial begin
    bit seen;
    in_valid  = '0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    cin_in    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check("reset_state", {27'd0, in_ready[s], out_valid[s], busy[s], cout[s], 1'b0},
            32'b10000);
      check("reset_sum", {24'd0, sum_of(s)}, 32'd0);
    end
    rst = 1'b0;

    run_op(0, 8'hFF, 8'h01, 1'b0, 0, 1'b0, "t1_w8d1");
    run_op(1, 8'h5A, 8'h33, 1'b1, 0, 1'b0, "t2_w8d2");
    run_op(0, 8'h5A, 8'h33, 1'b1, 10, 1'b0, "t3_bp");
    run_op(1, 8'h80, 8'h80, 1'b0, 10, 1'b0, "t3_bp_d2");
    run_op(0, 8'hC3, 8'h7E, 1'b0, 0, 1'b1, "t4_poke_d1");
    run_op(1, 8'h7F, 8'h01, 1'b0, 0, 1'b1, "t4_poke_d2");

    // Abort an 8-step operation after its third RUN edge.
    a_in        = 8'h0F;
    b_in        = 8'hF0;
    cin_in      = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_midrun_busy", {31'd0, busy[0]}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_after_rst", {28'd0, in_ready[0], out_valid[0], busy[0], cout[0]}, 32'b1000);
    check("t5_sum_clr", {24'd0, sum0}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen = 1'b1;
    end
    check("t5_no_result", {31'd0, seen}, 32'd0);

    run_op(2, 8'h0F, 8'h0F, 1'b1, 0, 1'b0, "t6_w4d4");
    for (int i = 0; i < 1000; i++)
      run_op(2, 8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0, "rnd_d4");
    for (int i = 0; i < 20; i++) begin
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0, "rnd_d1");
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0, "rnd_d2");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
